// File: rtl/hub75_scan.sv
// HUB75 1/16-scan panel driver: reads upper/lower pixel pairs from the frame
// memory, shifts one bit plane per pass, and shows it for a binary-weighted
// time (BCM). Issues the buffer-swap pulse only in the frame-end cycle.
module hub75_scan #(
  parameter int COLS   = 64,
  parameter int ROWS   = 32,
  parameter int PLANES = 8,
  parameter int T_UNIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        swap_req,
  output logic        mem_rd,
  output logic [11:0] mem_address,
  input  logic [23:0] mem_rdata,
  output logic        mem_change,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic        pclk,
  output logic        lat,
  output logic        oe_n,
  output logic [3:0]  row_addr,
  output logic        frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS / 2);
  localparam int PW = $clog2(PLANES);
  localparam int DW = $clog2(T_UNIT << (PLANES - 1)) + 1;

  typedef enum logic [2:0] {
    IDLE, SHIFT, LATCH, BLANK, DISPLAY, FEND
  } state_t;

  state_t            state;
  logic [RW-1:0]     row;
  logic [PW-1:0]     plane;
  logic [CW-1:0]     col;
  logic [1:0]        ph;
  logic [DW-1:0]     dcnt;
  logic              swap_pending;
  logic              r2_q, g2_q, b2_q;
  logic [PLANES-1:0] ch_r, ch_g, ch_b;

  assign ch_r = mem_rdata[2*PLANES +: PLANES];
  assign ch_g = mem_rdata[PLANES +: PLANES];
  assign ch_b = mem_rdata[0 +: PLANES];

  // Lower-half pixel arrives in shift cycle 2 only; show it live then and
  // hold the captured copy through the pclk-high cycle.
  assign r2 = (state == SHIFT && ph == 2'd2) ? ch_r[plane] : r2_q;
  assign g2 = (state == SHIFT && ph == 2'd2) ? ch_g[plane] : g2_q;
  assign b2 = (state == SHIFT && ph == 2'd2) ? ch_b[plane] : b2_q;

  // A request arriving in the frame-end cycle itself must swap immediately.
  assign mem_change = (state == FEND) && (swap_pending || swap_req);

  function automatic logic [11:0] rd_addr(input logic half,
                                          input logic [RW-1:0] r,
                                          input logic [CW-1:0] c);
    return 12'({half, r, c});
  endfunction

  // Scan sequencer with registered panel and memory strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      plane        <= '0;
      col          <= '0;
      ph           <= '0;
      dcnt         <= '0;
      swap_pending <= 1'b0;
      mem_rd       <= 1'b0;
      mem_address  <= '0;
      r1           <= 1'b0;
      g1           <= 1'b0;
      b1           <= 1'b0;
      r2_q         <= 1'b0;
      g2_q         <= 1'b0;
      b2_q         <= 1'b0;
      pclk         <= 1'b0;
      lat          <= 1'b0;
      oe_n         <= 1'b1;
      row_addr     <= '0;
      frame_done   <= 1'b0;
    end else begin
      if (swap_req && state != FEND) swap_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= SHIFT;
            row         <= '0;
            plane       <= '0;
            col         <= '0;
            ph          <= '0;
            mem_rd      <= 1'b1;
            mem_address <= rd_addr(1'b0, '0, '0);
          end
        end
        SHIFT: begin
          case (ph)
            2'd0: begin
              mem_address <= rd_addr(1'b1, row, col);
              ph          <= 2'd1;
            end
            2'd1: begin
              mem_rd <= 1'b0;
              r1     <= ch_r[plane];
              g1     <= ch_g[plane];
              b1     <= ch_b[plane];
              ph     <= 2'd2;
            end
            2'd2: begin
              r2_q <= ch_r[plane];
              g2_q <= ch_g[plane];
              b2_q <= ch_b[plane];
              pclk <= 1'b1;
              ph   <= 2'd3;
            end
            default: begin
              pclk <= 1'b0;
              ph   <= 2'd0;
              if (col == CW'(COLS - 1)) begin
                col      <= '0;
                state    <= LATCH;
                lat      <= 1'b1;
                row_addr <= 4'(row);
              end else begin
                col         <= col + 1'b1;
                mem_rd      <= 1'b1;
                mem_address <= rd_addr(1'b0, row, col + 1'b1);
              end
            end
          endcase
        end
        LATCH: begin
          lat   <= 1'b0;
          state <= BLANK;
        end
        BLANK: begin
          oe_n  <= 1'b0;
          dcnt  <= DW'((T_UNIT << plane) - 1);
          state <= DISPLAY;
        end
        DISPLAY: begin
          if (dcnt != '0) begin
            dcnt <= dcnt - 1'b1;
          end else begin
            oe_n <= 1'b1;
            if (plane != PW'(PLANES - 1)) begin
              plane       <= plane + 1'b1;
              state       <= SHIFT;
              mem_rd      <= 1'b1;
              mem_address <= rd_addr(1'b0, row, '0);
            end else begin
              plane <= '0;
              row   <= row + 1'b1;
              if (row == RW'(ROWS / 2 - 1)) begin
                state      <= FEND;
                frame_done <= 1'b1;
              end else begin
                state       <= SHIFT;
                mem_rd      <= 1'b1;
                mem_address <= rd_addr(1'b0, row + 1'b1, '0);
              end
            end
          end
        end
        FEND: begin
          frame_done   <= 1'b0;
          swap_pending <= 1'b0;
          if (enable) begin
            state       <= SHIFT;
            mem_rd      <= 1'b1;
            mem_address <= rd_addr(1'b0, '0, '0);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan.sv
// Scoreboard bench for hub75_scan: stimulus pushes expectations, a negedge
// monitor pops and compares whenever the DUT shows the matching event.
module tb_hub75_scan;

  localparam int T_UNIT    = 2;
  localparam int ROW_CYC   = 8 * (4 * 64 + 2) + T_UNIT * 255;
  localparam int FRAME_CYC = 16 * ROW_CYC + 1;

  logic        clk, rst_n, enable, swap_req;
  logic        mem_rd, mem_change;
  logic [11:0] mem_address;
  logic [23:0] mem_rdata;
  logic        r1, g1, b1, r2, g2, b2;
  logic        pclk, lat, oe_n, frame_done;
  logic [3:0]  row_addr;

  hub75_scan #(.T_UNIT(T_UNIT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .swap_req(swap_req),
    .mem_rd(mem_rd), .mem_address(mem_address), .mem_rdata(mem_rdata),
    .mem_change(mem_change), .r1(r1), .g1(g1), .b1(b1),
    .r2(r2), .g2(g2), .b2(b2), .pclk(pclk), .lat(lat), .oe_n(oe_n),
    .row_addr(row_addr), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame memory model: one-cycle read latency.
  function automatic logic [23:0] pix(input logic [11:0] a);
    case (a)
      12'd0:    return 24'hFF0000;
      12'd1024: return 24'h0000FF;
      12'd1:    return 24'h00FF00;
      12'd1025: return 24'h010080;
      12'd2:    return 24'h5500AA;
      default:  return 24'h000000;
    endcase
  endfunction

  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd) mem_rdata <= pix(mem_address);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct { logic rd; logic [11:0] addr; } rd_t;
  typedef struct { int idx; logic [5:0] rgb; } px_t;
  typedef struct { logic mc; int off; } fd_t;

  rd_t        rd_q[$];
  px_t        px_q[$];
  int         w_q[$];
  int         gap_q[$];
  logic [3:0] row_q[$];
  fd_t        fd_q[$];

  // Monitor state
  int         cyc = 0, start_cyc = 0, lat_cyc = 0, pcnt = 0, run = 0;
  bit         rd_arm = 0, start_arm = 1;
  logic       pclk_p = 0, oe_p = 1;
  logic [3:0] row_p = 0;
  rd_t        e;
  px_t        p;
  fd_t        f;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rd_arm = 0; pcnt = 0; pclk_p = 0; run = 0; oe_p = 1;
      row_p = row_addr; start_arm = 1;
    end else begin
      if (!rd_arm && mem_rd && rd_q.size() > 0) rd_arm = 1;
      if (rd_arm) begin
        if (rd_q.size() > 0) begin
          e = rd_q.pop_front();
          check("rd_strobe", mem_rd, e.rd);
          if (e.rd) check("rd_addr", mem_address, e.addr);
        end else rd_arm = 0;
      end
      if (start_arm && mem_rd) begin
        start_cyc = cyc;
        start_arm = 0;
      end
      if (pclk && !pclk_p) begin
        if (px_q.size() > 0 && px_q[0].idx == pcnt) begin
          p = px_q.pop_front();
          check("pixel", {r1, g1, b1, r2, g2, b2}, p.rgb);
        end
        pcnt++;
      end
      pclk_p = pclk;
      if (lat) lat_cyc = cyc;
      if (!oe_n) begin
        if (oe_p && gap_q.size() > 0) check("lat_gap", cyc - lat_cyc, gap_q.pop_front());
        run++;
      end else if (run > 0) begin
        if (w_q.size() > 0) check("oe_width", run, w_q.pop_front());
        run = 0;
      end
      oe_p = oe_n;
      if (row_addr != row_p) begin
        check("row_in_latch", lat, 1);
        check("row_oe_high", oe_n, 1);
        if (row_q.size() > 0) check("row_val", row_addr, row_q.pop_front());
        row_p = row_addr;
      end
      if (mem_change && !frame_done) check("swap_outside_fend", mem_change, 0);
      if (frame_done) begin
        start_arm = 1;
        if (fd_q.size() > 0) begin
          f = fd_q.pop_front();
          check("swap_pulse", mem_change, f.mc);
          check("frame_len", cyc - start_cyc, f.off);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_reads();
    rd_q.push_back('{1'b1, 12'd0});
    rd_q.push_back('{1'b1, 12'd1024});
    rd_q.push_back('{1'b0, 12'd0});
    rd_q.push_back('{1'b0, 12'd0});
    rd_q.push_back('{1'b1, 12'd1});
    rd_q.push_back('{1'b1, 12'd1025});
    rd_q.push_back('{1'b0, 12'd0});
    rd_q.push_back('{1'b0, 12'd0});
  endtask

  task automatic wait_fd(output bit got);
    got = 0;
    for (int i = 0; i < FRAME_CYC + 100; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        got = 1;
        break;
      end
    end
  endtask

  int   falls;
  logic prev;
  bit   got;

  initial begin
    rst_n = 0; enable = 1; swap_req = 0;
    repeat (3) @(negedge clk);
    check("rst_oe_n", oe_n, 1);
    check("rst_lat", lat, 0);
    check("rst_pclk", pclk, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_change", mem_change, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_row_addr", row_addr, 0);
    push_reads();
    tick();
    rst_n = 1;

    // Run into the plane-7 display of row 0, then reset asynchronously.
    falls = 0; prev = 1;
    for (int i = 0; i < 5000 && falls < 8; i++) begin
      @(posedge clk);
      #1;
      if (!oe_n && prev) falls++;
      prev = oe_n;
    end
    check("reach_plane7", falls, 8);
    repeat (10) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("async_rst_oe_n", oe_n, 1);
    check("async_rst_mem_rd", mem_rd, 0);

    push_reads();
    px_q.push_back('{0,   6'b100001});
    px_q.push_back('{1,   6'b010100});
    px_q.push_back('{2,   6'b100000});
    px_q.push_back('{64,  6'b100001});
    px_q.push_back('{65,  6'b010000});
    px_q.push_back('{66,  6'b001000});
    px_q.push_back('{449, 6'b010001});
    for (int b = 0; b < 8; b++) begin
      w_q.push_back(T_UNIT << b);
      gap_q.push_back(2);
    end
    for (int r = 1; r < 16; r++) row_q.push_back(4'(r));
    row_q.push_back(4'd0);
    fd_q.push_back('{1'b1, FRAME_CYC - 1});
    tick();
    rst_n = 1;

    // Frame A: several mid-frame swap requests, enable dropped mid-frame.
    repeat (3000) tick();
    swap_req = 1;
    tick();
    swap_req = 0;
    repeat (9000) tick();
    swap_req = 1;
    repeat (2) tick();
    swap_req = 0;
    repeat (5000) tick();
    enable = 0;
    wait_fd(got);
    check("frameA_done_seen", got, 1);
    @(posedge clk);
    #1;
    check("frame_done_one_cycle", frame_done, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_oe_n", oe_n, 1);
      check("idle_mem_rd", mem_rd, 0);
    end

    // Frame B: no pending request; request raised inside the frame-end cycle.
    fd_q.push_back('{1'b1, FRAME_CYC - 1});
    enable = 1;
    wait_fd(got);
    check("frameB_done_seen", got, 1);
    check("no_req_no_swap", mem_change, 0);
    #1 swap_req = 1;
    #1 check("fend_req_swap", mem_change, 1);
    @(negedge clk);
    #2 swap_req = 0;
    enable = 0;
    repeat (10) tick();

    check("rd_q_drained", rd_q.size(), 0);
    check("px_q_drained", px_q.size(), 0);
    check("w_q_drained", w_q.size(), 0);
    check("gap_q_drained", gap_q.size(), 0);
    check("row_q_drained", row_q.size(), 0);
    check("fd_q_drained", fd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_scan.md
Name: hub75_scan

Overview:
- Downstream consumer of the double-buffered 2048x24 frame memory. It drives a 64x32 HUB75 RGB LED panel with 1/16 scan.
- Reads pixel pairs from the memory's read port and serialises them to the panel using 8-bit binary-coded modulation.
- At frame boundaries it issues the one-cycle buffer-swap pulse, so the writer and the display exchange buffers without tearing.

Parameters:
- COLS, 64, panel columns per row
- ROWS, 32, panel rows; upper half rows 0..15, lower half rows 16..31
- PLANES, 8, bits per colour channel
- T_UNIT, 4, oe_n-low cycles for bit plane 0; plane b lasts T_UNIT<<b

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run scanning; sampled only in IDLE and at frame end
- swap_req  in  1  request buffer swap; level or pulse, latched
- mem_rd  out  1  read strobe to frame memory
- mem_address  out  12  read address; bit 11 always 0
- mem_rdata  in  24  pixel data {R[23:16],G[15:8],B[7:0]}; valid the cycle after mem_rd
- mem_change  out  1  one-cycle swap pulse to frame memory
- r1,g1,b1  out  1 each  upper-half colour bits
- r2,g2,b2  out  1 each  lower-half colour bits
- pclk  out  1  panel shift clock; data valid on its rising edge
- lat  out  1  panel latch strobe
- oe_n  out  1  panel output enable, active low
- row_addr  out  4  panel row select A..D
- frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - All outputs 0 except oe_n=1.
  - row_addr=0, plane=0, col=0, swap_pending=0.
- States: IDLE -> SHIFT -> LATCH -> BLANK -> DISPLAY -> (SHIFT | frame end).
- IDLE: oe_n=1. Goes to SHIFT with row=0, plane=0, col=0 when enable=1.
- SHIFT: 4 cycles per column c, for cols 0..COLS-1.
  - Cycle 0: mem_rd=1, mem_address=row*64+c.
  - Cycle 1: mem_rd=1, mem_address=(row+16)*64+c. Capture upper pixel.
  - Cycle 2: capture lower pixel. Drive r1=R_up[plane], g1=G_up[plane], b1=B_up[plane], and r2/g2/b2 from the lower pixel. pclk=0.
  - Cycle 3: pclk=1.
  - mem_rd=0 in cycles 2 and 3.
  - oe_n=1 throughout SHIFT.
  - 256 cycles per plane.
- LATCH: 1 cycle, lat=1. row_addr updates to the current row in this cycle; oe_n stays 1.
- BLANK: 1 cycle, lat=0, oe_n=1. Dead time.
- DISPLAY: oe_n=0 for exactly T_UNIT<<plane cycles, then oe_n=1. Next step:
  - plane<PLANES-1: plane+1, go to SHIFT.
  - Otherwise plane=0, row+1. If row was 15, take frame end.
- Frame end, a single cycle after the last DISPLAY:
  - frame_done=1.
  - If swap_pending, or swap_req=1 in this same cycle: mem_change=1 and swap_pending cleared.
  - Then go to SHIFT (row=0) if enable=1, else IDLE.
- swap_req=1 in any other cycle sets swap_pending. Multiple requests within one frame produce exactly one mem_change. mem_change is never asserted outside frame end.
- Frame length with defaults: per row = 8*(256+2) + 4*255 = 3084 cycles. Frame = 16*3084 + 1 = 49345 cycles.
- enable deasserted mid-frame: ignored until frame end.
- Reset mid-operation: oe_n goes 1 immediately; the scan restarts at row 0, plane 0 after release.
- Row address changes only while oe_n=1.

Test Plan:
- Reset: hold rst_n=0 -> oe_n=1, lat=0, pclk=0, mem_rd=0, mem_change=0, row_addr=0. Release with enable=1 -> first mem_address sequence is 0, 1024, (idle), (idle), 1, 1025, ...
- Pixel mapping: memory model returns 0xFF0000 at address 0 and 0x0000FF at address 1024. Plane 0, col 0 -> r1=1,g1=0,b1=0,r2=0,g2=0,b2=1 at the first pclk rising edge.
- BCM timing: measure oe_n-low widths over one row -> 4, 8, 16, 32, 64, 128, 256, 512 cycles. Each is preceded by a lat pulse followed by one oe_n-high cycle.
- Swap:
  - Pulse swap_req for 1 cycle mid-frame -> exactly one mem_change pulse, coincident with frame_done, 49345 cycles after the scan start.
  - No swap_req -> no mem_change.
  - swap_req asserted in the frame-end cycle itself -> mem_change in that same cycle.
- Row stepping and disable:
  - row_addr steps 0..15, changing only in LATCH cycles while oe_n=1.
  - Drop enable mid-frame -> the frame completes, frame_done pulses, state goes to IDLE, oe_n stays 1.
- Reset mid-display: assert rst_n=0 during a plane-7 DISPLAY -> oe_n=1 asynchronously. After release, the next read addresses are 0 and 1024.
